// File: rtl/wb_interconnect_param_if.sv
// Wishbone bus bundle between the CPU master, the interconnect and its NSLV slaves.
// Signal suffixes are from the interconnect's point of view.
interface wb_interconnect_param_if #(
    parameter int NSLV = 4,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    logic               wbm_cyc_i;
    logic               wbm_stb_i;
    logic               wbm_we_i;
    logic [AW-1:0]      wbm_adr_i;
    logic [DW-1:0]      wbm_dat_i;
    logic [DW-1:0]      wbm_dat_o;
    logic               wbm_ack_o;
    logic               wbm_err_o;

    logic [NSLV-1:0]    wbs_cyc_o;
    logic [NSLV-1:0]    wbs_stb_o;
    logic               wbs_we_o;
    logic [AW-1:0]      wbs_adr_o;
    logic [DW-1:0]      wbs_dat_o;
    logic [NSLV*DW-1:0] wbs_dat_i;
    logic [NSLV-1:0]    wbs_ack_i;

    // The interconnect acts as the slave of the CPU bus.
    modport slave (
        input  wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_adr_i, wbm_dat_i, wbs_dat_i, wbs_ack_i,
        output wbm_dat_o, wbm_ack_o, wbm_err_o, wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o
    );

    modport master (
        output wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_adr_i, wbm_dat_i, wbs_dat_i, wbs_ack_i,
        input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_interconnect_param.sv
// Single-master Wishbone classic interconnect with base/mask decode, registered request,
// bus-timeout watchdog and error counting / last-error-address capture.
module wb_interconnect_param #(
    parameter int                 NSLV     = 4,
    parameter int                 AW       = 32,
    parameter int                 DW       = 32,
    parameter logic [NSLV*AW-1:0] SLV_BASE = {32'h3000_0000, 32'h2000_0000,
                                              32'h1000_0000, 32'h0000_0000},
    parameter logic [NSLV*AW-1:0] SLV_MASK = {NSLV{32'hF000_0000}},
    parameter int                 TIMEOUT  = 255
) (
    input  logic                          wb_clk,
    input  logic                          wb_rst,
    wb_interconnect_param_if.slave        bus,
    output logic [15:0]                   err_count_o,
    output logic [AW-1:0]                 err_adr_o
);

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_e;

    state_e          state_q, state_d;
    logic [NSLV-1:0] sel_q, sel_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            resp_err_q, resp_err_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   wdat_q, wdat_d;
    logic            we_q, we_d;
    logic [DW-1:0]   rdat_q, rdat_d;
    logic [15:0]     err_cnt_q, err_cnt_d;
    logic [AW-1:0]   err_adr_q, err_adr_d;

    logic [NSLV-1:0] match_sel;
    logic            sel_ack;
    logic [DW-1:0]   sel_dat;
    logic            raise_err;

    // Descending scan so the lowest-index matching slave overwrites any higher match.
    always_comb begin
        match_sel = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((bus.wbm_adr_i & SLV_MASK[i*AW +: AW]) ==
                (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW])) begin
                match_sel    = '0;
                match_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_dat = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel_q[i]) sel_dat = sel_dat | bus.wbs_dat_i[i*DW +: DW];
        end
    end

    assign sel_ack = |(bus.wbs_ack_i & sel_q);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        resp_err_d = resp_err_q;
        adr_d      = adr_q;
        wdat_d     = wdat_q;
        we_d       = we_q;
        rdat_d     = rdat_q;
        err_cnt_d  = err_cnt_q;
        err_adr_d  = err_adr_q;
        raise_err  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.wbm_cyc_i && bus.wbm_stb_i) begin
                    adr_d  = bus.wbm_adr_i;
                    wdat_d = bus.wbm_dat_i;
                    we_d   = bus.wbm_we_i;
                    if (|match_sel) begin
                        sel_d   = match_sel;
                        cnt_d   = '0;
                        state_d = ACTIVE;
                    end else begin
                        raise_err = 1'b1;
                        err_adr_d = bus.wbm_adr_i;
                    end
                end
            end
            ACTIVE: begin
                if (!bus.wbm_cyc_i) begin
                    state_d = IDLE;
                end else if (sel_ack) begin
                    rdat_d     = sel_dat;
                    resp_err_d = 1'b0;
                    state_d    = RESP;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    raise_err = 1'b1;
                    err_adr_d = adr_q;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Unmapped and timeout terminations share the same bookkeeping.
        if (raise_err) begin
            resp_err_d = 1'b1;
            rdat_d     = '0;
            state_d    = RESP;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            cnt_q      <= '0;
            resp_err_q <= 1'b0;
            adr_q      <= '0;
            wdat_q     <= '0;
            we_q       <= 1'b0;
            rdat_q     <= '0;
            err_cnt_q  <= '0;
            err_adr_q  <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            resp_err_q <= resp_err_d;
            adr_q      <= adr_d;
            wdat_q     <= wdat_d;
            we_q       <= we_d;
            rdat_q     <= rdat_d;
            err_cnt_q  <= err_cnt_d;
            err_adr_q  <= err_adr_d;
        end
    end

    assign bus.wbs_cyc_o = (state_q == ACTIVE) ? sel_q : '0;
    assign bus.wbs_stb_o = (state_q == ACTIVE) ? sel_q : '0;
    assign bus.wbs_we_o  = we_q;
    assign bus.wbs_adr_o = adr_q;
    assign bus.wbs_dat_o = wdat_q;
    assign bus.wbm_dat_o = rdat_q;
    assign bus.wbm_ack_o = (state_q == RESP) && !resp_err_q;
    assign bus.wbm_err_o = (state_q == RESP) && resp_err_q;
    assign err_count_o   = err_cnt_q;
    assign err_adr_o     = err_adr_q;

endmodule

// File: tb/tb_wb_interconnect_param.sv
// Directed bench for wb_interconnect_param: 4 slaves at 0x0/0x1/0x2/0x3 in the top nibble, TIMEOUT=8.
module tb_wb_interconnect_param;

    logic        wb_clk;
    logic        wb_rst;
    logic [15:0] err_count_o;
    logic [31:0] err_adr_o;
    int          checks = 0;
    int          errors = 0;

    wb_interconnect_param_if #(.NSLV(4), .AW(32), .DW(32)) bus ();

    wb_interconnect_param #(
        .NSLV    (4),
        .AW      (32),
        .DW      (32),
        .SLV_BASE({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .SLV_MASK({4{32'hF000_0000}}),
        .TIMEOUT (8)
    ) dut (
        .wb_clk     (wb_clk),
        .wb_rst     (wb_rst),
        .bus        (bus),
        .err_count_o(err_count_o),
        .err_adr_o  (err_adr_o)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drives one master request from a negedge; cycle c is observed at the c-th following negedge.
    task automatic run_txn(
        input  logic [31:0]      adr, input logic we, input logic [31:0] wdat,
        input  int               ackSlave, input int ackCycle, input logic [31:0] rdata,
        input  int               straySlave, input int strayCycle,
        input  int               dropCycle, input int maxCycles,
        output int               ackAt, output int errAt, output int ackCnt, output int errCnt,
        output logic [3:0]       stbOr, output logic [15:0][3:0] stbHist,
        output logic             weSeen, output logic [31:0] adrSeen, output logic [31:0] datSeen);
        ackAt = 0; errAt = 0; ackCnt = 0; errCnt = 0;
        stbOr = '0; stbHist = '0; weSeen = 1'b0; adrSeen = '0; datSeen = '0;
        bus.wbm_cyc_i = 1'b1;
        bus.wbm_stb_i = 1'b1;
        bus.wbm_we_i  = we;
        bus.wbm_adr_i = adr;
        bus.wbm_dat_i = wdat;
        for (int c = 1; c <= maxCycles; c++) begin
            @(negedge wb_clk);
            if (bus.wbm_ack_o) begin ackCnt++; if (ackAt == 0) ackAt = c; end
            if (bus.wbm_err_o) begin errCnt++; if (errAt == 0) errAt = c; end
            stbOr = stbOr | bus.wbs_stb_o;
            if (c < 16) stbHist[c] = bus.wbs_stb_o;
            if (c == 1) begin
                weSeen  = bus.wbs_we_o;
                adrSeen = bus.wbs_adr_o;
                datSeen = bus.wbs_dat_o;
            end
            if (bus.wbm_ack_o || bus.wbm_err_o || c == dropCycle) begin
                bus.wbm_cyc_i = 1'b0;
                bus.wbm_stb_i = 1'b0;
            end
            bus.wbs_ack_i = '0;
            bus.wbs_dat_i = '0;
            if (c == strayCycle && straySlave >= 0) begin
                bus.wbs_ack_i[straySlave]          = 1'b1;
                bus.wbs_dat_i[straySlave*32 +: 32] = 32'hBAD0_BAD0;
            end
            if (c == ackCycle && ackSlave >= 0) begin
                bus.wbs_ack_i[ackSlave]          = 1'b1;
                bus.wbs_dat_i[ackSlave*32 +: 32] = rdata;
            end
        end
        bus.wbm_cyc_i = 1'b0;
        bus.wbm_stb_i = 1'b0;
        bus.wbs_ack_i = '0;
        bus.wbs_dat_i = '0;
    endtask

    task automatic test_reset();
        wb_rst = 1'b1;
        bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0; bus.wbm_we_i = 1'b0;
        bus.wbm_adr_i = '0;   bus.wbm_dat_i = '0;
        bus.wbs_ack_i = '0;   bus.wbs_dat_i = '0;
        repeat (3) @(negedge wb_clk);
        wb_rst = 1'b0;
        @(negedge wb_clk);
        checks++;
        if ({bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_we_o, bus.wbm_ack_o, bus.wbm_err_o} !== 11'b0) begin
            errors++; $display("[TB] FAIL reset_ctrl: got %b expected 0",
                {bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_we_o, bus.wbm_ack_o, bus.wbm_err_o});
        end
        checks++;
        if ({bus.wbs_adr_o, bus.wbs_dat_o, bus.wbm_dat_o} !== 96'b0) begin
            errors++; $display("[TB] FAIL reset_data: adr %h dat %h rdat %h expected 0",
                bus.wbs_adr_o, bus.wbs_dat_o, bus.wbm_dat_o);
        end
        checks++;
        if (err_count_o !== 16'h0 || err_adr_o !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_err: count %h adr %h expected 0", err_count_o, err_adr_o);
        end
    endtask

    task automatic test_read();
        int ackAt, errAt, ackCnt, errCnt;
        logic [3:0] stbOr; logic [15:0][3:0] hist; logic weS; logic [31:0] adrS, datS;
        run_txn(32'h1000_0004, 1'b0, 32'h0, 1, 2, 32'hDEAD_BEEF, -1, 0, 0, 8,
                ackAt, errAt, ackCnt, errCnt, stbOr, hist, weS, adrS, datS);
        checks++;
        if (ackAt !== 3 || ackCnt !== 1 || errCnt !== 0) begin
            errors++; $display("[TB] FAIL read_ack: at %0d count %0d errs %0d expected 3/1/0", ackAt, ackCnt, errCnt);
        end
        checks++;
        if (stbOr !== 4'b0010) begin
            errors++; $display("[TB] FAIL read_strobe: got %b expected 0010", stbOr);
        end
        checks++;
        if (bus.wbm_dat_o !== 32'hDEAD_BEEF) begin
            errors++; $display("[TB] FAIL read_data: got %h expected deadbeef", bus.wbm_dat_o);
        end
    endtask

    task automatic test_write();
        int ackAt, errAt, ackCnt, errCnt;
        logic [3:0] stbOr; logic [15:0][3:0] hist; logic weS; logic [31:0] adrS, datS;
        run_txn(32'h2000_0008, 1'b1, 32'h55, 2, 1, 32'h0000_1234, -1, 0, 0, 6,
                ackAt, errAt, ackCnt, errCnt, stbOr, hist, weS, adrS, datS);
        checks++;
        if (weS !== 1'b1 || adrS !== 32'h2000_0008 || datS !== 32'h55) begin
            errors++; $display("[TB] FAIL write_fields: we %b adr %h dat %h expected 1/20000008/55", weS, adrS, datS);
        end
        checks++;
        if (stbOr !== 4'b0100) begin
            errors++; $display("[TB] FAIL write_strobe: got %b expected 0100", stbOr);
        end
        checks++;
        if (ackAt !== 2 || ackCnt !== 1 || errCnt !== 0) begin
            errors++; $display("[TB] FAIL write_ack: at %0d count %0d errs %0d expected 2/1/0", ackAt, ackCnt, errCnt);
        end
        checks++;
        if (bus.wbm_dat_o !== 32'h0000_1234) begin
            errors++; $display("[TB] FAIL write_capture: got %h expected 00001234", bus.wbm_dat_o);
        end
    endtask

    task automatic test_unmapped();
        int ackAt, errAt, ackCnt, errCnt;
        logic [3:0] stbOr; logic [15:0][3:0] hist; logic weS; logic [31:0] adrS, datS;
        run_txn(32'h8000_0000, 1'b0, 32'h0, -1, 0, 32'h0, -1, 0, 0, 5,
                ackAt, errAt, ackCnt, errCnt, stbOr, hist, weS, adrS, datS);
        checks++;
        if (errAt !== 1 || errCnt !== 1 || ackCnt !== 0) begin
            errors++; $display("[TB] FAIL unmapped_err: at %0d count %0d acks %0d expected 1/1/0", errAt, errCnt, ackCnt);
        end
        checks++;
        if (stbOr !== 4'b0000) begin
            errors++; $display("[TB] FAIL unmapped_strobe: got %b expected 0000", stbOr);
        end
        checks++;
        if (err_count_o !== 16'd1 || err_adr_o !== 32'h8000_0000) begin
            errors++; $display("[TB] FAIL unmapped_log: count %0d adr %h expected 1/80000000", err_count_o, err_adr_o);
        end
        checks++;
        if (bus.wbm_dat_o !== 32'h0) begin
            errors++; $display("[TB] FAIL unmapped_data: got %h expected 0", bus.wbm_dat_o);
        end
    endtask

    task automatic test_timeout();
        int ackAt, errAt, ackCnt, errCnt;
        logic [3:0] stbOr; logic [15:0][3:0] hist; logic weS; logic [31:0] adrS, datS;
        run_txn(32'h3000_0010, 1'b0, 32'h0, -1, 0, 32'h0, -1, 0, 0, 14,
                ackAt, errAt, ackCnt, errCnt, stbOr, hist, weS, adrS, datS);
        checks++;
        if (errAt !== 9 || errCnt !== 1 || ackCnt !== 0) begin
            errors++; $display("[TB] FAIL timeout_err: at %0d count %0d acks %0d expected 9/1/0", errAt, errCnt, ackCnt);
        end
        checks++;
        if (hist[8] !== 4'b1000 || hist[9] !== 4'b0000) begin
            errors++; $display("[TB] FAIL timeout_strobe: c8 %b c9 %b expected 1000/0000", hist[8], hist[9]);
        end
        checks++;
        if (err_count_o !== 16'd2 || err_adr_o !== 32'h3000_0010) begin
            errors++; $display("[TB] FAIL timeout_log: count %0d adr %h expected 2/30000010", err_count_o, err_adr_o);
        end
    endtask

    task automatic test_ack_vs_timeout();
        int ackAt, errAt, ackCnt, errCnt;
        logic [3:0] stbOr; logic [15:0][3:0] hist; logic weS; logic [31:0] adrS, datS;
        run_txn(32'h3000_0020, 1'b0, 32'h0, 3, 8, 32'hA5A5_0001, -1, 0, 0, 14,
                ackAt, errAt, ackCnt, errCnt, stbOr, hist, weS, adrS, datS);
        checks++;
        if (ackAt !== 9 || ackCnt !== 1 || errCnt !== 0) begin
            errors++; $display("[TB] FAIL race_ack: at %0d count %0d errs %0d expected 9/1/0", ackAt, ackCnt, errCnt);
        end
        checks++;
        if (err_count_o !== 16'd2 || bus.wbm_dat_o !== 32'hA5A5_0001) begin
            errors++; $display("[TB] FAIL race_state: count %0d data %h expected 2/a5a50001", err_count_o, bus.wbm_dat_o);
        end
    endtask

    task automatic test_stray_ack();
        int ackAt, errAt, ackCnt, errCnt;
        logic [3:0] stbOr; logic [15:0][3:0] hist; logic weS; logic [31:0] adrS, datS;
        run_txn(32'h2000_0000, 1'b0, 32'h0, 2, 3, 32'h2222_2222, 0, 1, 0, 8,
                ackAt, errAt, ackCnt, errCnt, stbOr, hist, weS, adrS, datS);
        checks++;
        if (ackAt !== 4 || ackCnt !== 1 || stbOr !== 4'b0100) begin
            errors++; $display("[TB] FAIL stray_ack: at %0d count %0d stb %b expected 4/1/0100", ackAt, ackCnt, stbOr);
        end
        checks++;
        if (bus.wbm_dat_o !== 32'h2222_2222) begin
            errors++; $display("[TB] FAIL stray_data: got %h expected 22222222", bus.wbm_dat_o);
        end
    endtask

    task automatic test_abort();
        int ackAt, errAt, ackCnt, errCnt;
        logic [3:0] stbOr; logic [15:0][3:0] hist; logic weS; logic [31:0] adrS, datS;
        // The late ack arrives while idle and must be ignored.
        run_txn(32'h1000_0000, 1'b0, 32'h0, 1, 4, 32'h1111_1111, -1, 0, 2, 12,
                ackAt, errAt, ackCnt, errCnt, stbOr, hist, weS, adrS, datS);
        checks++;
        if (hist[2] !== 4'b0010 || hist[3] !== 4'b0000) begin
            errors++; $display("[TB] FAIL abort_strobe: c2 %b c3 %b expected 0010/0000", hist[2], hist[3]);
        end
        checks++;
        if (ackCnt !== 0 || errCnt !== 0) begin
            errors++; $display("[TB] FAIL abort_resp: acks %0d errs %0d expected 0/0", ackCnt, errCnt);
        end
        checks++;
        if (bus.wbm_dat_o !== 32'h2222_2222 || err_count_o !== 16'd2) begin
            errors++; $display("[TB] FAIL abort_state: data %h count %0d expected 22222222/2", bus.wbm_dat_o, err_count_o);
        end
    endtask

    task automatic test_reset_mid();
        int resp = 0;
        bus.wbm_cyc_i = 1'b1; bus.wbm_stb_i = 1'b1; bus.wbm_we_i = 1'b1;
        bus.wbm_adr_i = 32'h1000_0000; bus.wbm_dat_i = 32'h77;
        @(negedge wb_clk);
        @(negedge wb_clk);
        checks++;
        if (bus.wbs_stb_o !== 4'b0010 || bus.wbs_we_o !== 1'b1) begin
            errors++; $display("[TB] FAIL rstmid_active: stb %b we %b expected 0010/1", bus.wbs_stb_o, bus.wbs_we_o);
        end
        wb_rst = 1'b1;
        @(negedge wb_clk);
        checks++;
        if ({bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_we_o, bus.wbm_ack_o, bus.wbm_err_o} !== 11'b0 ||
            bus.wbs_adr_o !== 32'h0 || bus.wbs_dat_o !== 32'h0) begin
            errors++; $display("[TB] FAIL rstmid_bus: stb %b we %b adr %h dat %h expected all 0",
                bus.wbs_stb_o, bus.wbs_we_o, bus.wbs_adr_o, bus.wbs_dat_o);
        end
        checks++;
        if (bus.wbm_dat_o !== 32'h0 || err_count_o !== 16'h0 || err_adr_o !== 32'h0) begin
            errors++; $display("[TB] FAIL rstmid_regs: data %h count %h adr %h expected 0",
                bus.wbm_dat_o, err_count_o, err_adr_o);
        end
        wb_rst = 1'b0;
        bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0; bus.wbm_we_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge wb_clk);
            if (bus.wbm_ack_o || bus.wbm_err_o) resp++;
        end
        checks++;
        if (resp !== 0) begin
            errors++; $display("[TB] FAIL rstmid_resp: got %0d responses expected 0", resp);
        end
    endtask

    task automatic test_saturation();
        int errs = 0;
        // Preload the counter near saturation; 65535 real errors would need ~131k cycles.
        force dut.err_cnt_d = 16'hFFFC;
        @(negedge wb_clk);
        release dut.err_cnt_d;
        checks++;
        if (err_count_o !== 16'hFFFC) begin
            errors++; $display("[TB] FAIL sat_preload: got %h expected fffc", err_count_o);
        end
        // A strobe held high re-requests every IDLE cycle: errors land in odd cycles.
        bus.wbm_cyc_i = 1'b1; bus.wbm_stb_i = 1'b1; bus.wbm_we_i = 1'b0;
        bus.wbm_adr_i = 32'h9000_0000;
        for (int c = 1; c <= 10; c++) begin
            @(negedge wb_clk);
            if (bus.wbm_err_o) errs++;
            if (c == 1) begin
                checks++;
                if (err_count_o !== 16'hFFFD) begin
                    errors++; $display("[TB] FAIL sat_first: got %h expected fffd", err_count_o);
                end
            end
            if (c == 10) begin
                bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0;
            end
        end
        checks++;
        if (errs !== 5 || err_count_o !== 16'hFFFF) begin
            errors++; $display("[TB] FAIL sat_final: errs %0d count %h expected 5/ffff", errs, err_count_o);
        end
        checks++;
        if (err_adr_o !== 32'h9000_0000) begin
            errors++; $display("[TB] FAIL sat_adr: got %h expected 90000000", err_adr_o);
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_read();
        test_write();
        test_unmapped();
        test_timeout();
        test_ack_vs_timeout();
        test_stray_ack();
        test_abort();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
